mtl2_timer_host: RTL
====================

Name: mtl2_timer_host

Overview:
Avalon-MM initiator that drives the MTL2 interval-timer slave (16-bit data, 3-bit word address) from hardware, with no CPU involved. It programs the period, starts the timer, services the timer IRQ by clearing its status, and counts timeouts. On request it takes a counter snapshot and reads it back. It sits beside the timer in the MTL2 painter subsystem and feeds tick pulses to the display refresh logic.

Parameters:
DEFAULT_PERIOD, 32'd19999, period loaded when start is pulsed with period_in == 0 (see Behaviour).
TICK_W, 32, width of tick_count.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle request: program the timer and run it
stop  in  1  one-cycle request: stop the timer
snap_req  in  1  one-cycle request: snapshot and read the counter
period_in  in  32  timer period, sampled on an accepted start
continuous_in  in  1  continuous mode, sampled on an accepted start
irq  in  1  timer interrupt (level)
readdata  in  16  timer read data; registered, valid 1 cycle after the address is presented
address  out  3  timer word address
chipselect  out  1  bus select
write_n  out  1  active-low write
writedata  out  16  write data
running  out  1  high in RUN and in the states entered from RUN
busy  out  1  high whenever the state is not IDLE or RUN
tick  out  1  one-cycle pulse per serviced timeout
tick_count  out  TICK_W  serviced-timeout count; wraps
snapshot  out  32  last snapshot value read back
snapshot_valid  out  1  one-cycle pulse when snapshot updates

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, port name reset.
- Reset values: all outputs 0, except write_n = 1. State = IDLE. Pending flags cleared. A reset mid-sequence drops the bus to idle immediately and does not finish the bus sequence.
- Idle bus: chipselect = 0, write_n = 1, address = 0, writedata = 0.
- Bus access: every access is single-cycle with no wait states.
  - Write: chipselect = 1 and write_n = 0 for exactly one cycle.
  - Read: chipselect = 1 and write_n = 1; data is captured from readdata on the next cycle.
- FSM states: IDLE, CFG_L, CFG_H, CFG_CTRL, RUN, ACK, STOP_WR, SNAP_WR, SNAP_RD_L, SNAP_RD_H, SNAP_CAP.
- IDLE: start latches period (period_in, or DEFAULT_PERIOD when period_in == 0) and continuous_in, then goes to CFG_L. stop and snap_req in IDLE are ignored.
- Configuration writes, one cycle each:
  - CFG_L: address 2, data period[15:0].
  - CFG_H: address 3, data period[31:16].
  - CFG_CTRL: address 1, data {12'b0, 1'b0, 1'b1, cont, 1'b1} (START, CONT, ITO).
  - CFG_CTRL is followed by RUN.
- RUN priority, highest first: irq, then pending stop, then pending snapshot.
- ACK: write address 0, data 0 (clears the timeout). tick = 1 and tick_count += 1 (modulo 2^TICK_W) in this same cycle. Next state is RUN if cont = 1, otherwise IDLE (the timer has self-stopped). irq falls in the cycle after ACK.
- STOP_WR: write address 1, data 16'h0008 (STOP, ITO = 0), then IDLE. A pending stop is cleared on entry.
- Snapshot sequence:
  - SNAP_WR: write address 4, data 0.
  - SNAP_RD_L: read address 4.
  - SNAP_RD_H: read address 5; capture readdata into snapshot[15:0].
  - SNAP_CAP: capture readdata into snapshot[31:16] and pulse snapshot_valid; then RUN.
- Pending requests:
  - stop or snap_req arriving in any non-IDLE state sets a pending flag. Repeated requests collapse into one.
  - start in any non-IDLE state is ignored.
  - irq asserted during the CFG, SNAP or STOP_WR states is held by the timer and serviced on return to RUN. After STOP_WR, a held irq is not serviced.
- Known limitation: a timeout that coincides with the ACK write is lost, because the timer gives its status-clear priority. tick_count therefore counts serviced timeouts only.
- Latency:
  - start to CFG_CTRL write: 3 cycles.
  - irq high in RUN to tick: 1 cycle.
  - snap_req in RUN to snapshot_valid: 4 cycles.

Test Plan:
- Reset, then start with period_in = 32'h0001_86A0, continuous_in = 1 -> writes (2, 86A0), (3, 0001), (1, 0007) on consecutive cycles; running = 1 afterwards.
- Continuous mode: assert irq 3 times, each held until the ACK write -> each irq gives one write (0, 0000) and one tick pulse; tick_count = 3; state stays RUN.
- One-shot: start with continuous_in = 0 and period_in = 0 -> period written is 19999 (writes 4E1F, 0000, 0005); first irq -> ACK, then IDLE, running = 0.
- Snapshot: in RUN, pulse snap_req; model readdata 1234 for address 4 and 0056 for address 5 -> write (4, 0), reads at addresses 4 then 5, snapshot = 32'h0056_1234, snapshot_valid pulses exactly once.
- Simultaneous events: pulse stop during CFG_H while irq is high at RUN entry -> ACK serviced first, then write (1, 0008), then IDLE. A snap_req during CFG_L is serviced after the stop is not taken, i.e. it is dropped because the block returns to IDLE.
- Asynchronous reset asserted during SNAP_RD_L -> chipselect = 0 and write_n = 1 immediately; tick_count = 0; a later start reconfigures normally.

Source files
------------

// File: rtl/mtl2_timer_host_if.sv
// Avalon-MM bus between mtl2_timer_host (initiator) and the MTL2 interval-timer slave.
//   address    : timer word address (3 bits)
//   chipselect : bus select
//   write_n    : active-low write strobe (high with chipselect = read)
//   writedata  : 16-bit write data
//   readdata   : 16-bit read data, registered by the slave (valid the cycle after the address)
interface mtl2_timer_host_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/mtl2_timer_host.sv
// mtl2_timer_host: hardware initiator for the MTL2 interval timer.
// Programs the period, starts the timer, clears the timeout status on every
// IRQ (one tick pulse per serviced timeout) and reads back counter snapshots.
//
// Ports:
//   clk, reset       : clock, asynchronous active-high reset
//   start            : program period_in/continuous_in and run (ignored unless IDLE)
//   stop             : stop the timer (held pending until serviced in RUN)
//   snap_req         : snapshot and read back the counter (held pending)
//   period_in        : timer period; 0 selects DEFAULT_PERIOD
//   continuous_in    : continuous mode select
//   irq              : timer interrupt (level)
//   bus              : Avalon-MM master to the timer
//   running          : RUN or a state entered from RUN
//   busy             : any state other than IDLE and RUN
//   tick             : one-cycle pulse per serviced timeout
//   tick_count       : serviced-timeout count, wraps
//   snapshot         : last counter snapshot
//   snapshot_valid   : one-cycle pulse when snapshot updates
module mtl2_timer_host #(
  parameter logic [31:0] DEFAULT_PERIOD = 32'd19999,
  parameter int          TICK_W         = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              snap_req,
  input  logic [31:0]       period_in,
  input  logic              continuous_in,
  input  logic              irq,
  mtl2_timer_host_if.master bus,
  output logic              running,
  output logic              busy,
  output logic              tick,
  output logic [TICK_W-1:0] tick_count,
  output logic [31:0]       snapshot,
  output logic              snapshot_valid
);

  typedef enum logic [3:0] {
    IDLE,
    CFG_L,
    CFG_H,
    CFG_CTRL,
    RUN,
    ACK,
    STOP_WR,
    SNAP_WR,
    SNAP_RD_L,
    SNAP_RD_H,
    SNAP_CAP
  } state_t;

  // Timer register map (word addresses)
  localparam logic [2:0] A_STATUS  = 3'd0;
  localparam logic [2:0] A_CONTROL = 3'd1;
  localparam logic [2:0] A_PERIODL = 3'd2;
  localparam logic [2:0] A_PERIODH = 3'd3;
  localparam logic [2:0] A_SNAPL   = 3'd4;
  localparam logic [2:0] A_SNAPH   = 3'd5;

  localparam logic [TICK_W-1:0] TICK_ONE = {{(TICK_W-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [31:0]         period_q, period_d;
  logic                cont_q, cont_d;
  logic                stop_pend_q, stop_pend_d;
  logic                snap_pend_q, snap_pend_d;
  logic [TICK_W-1:0]   tick_count_q, tick_count_d;
  logic [15:0]         snap_lo_q, snap_lo_d;
  logic [31:0]         snapshot_q, snapshot_d;

  logic [2:0]          bus_addr;
  logic                bus_cs;
  logic                bus_wn;
  logic [15:0]         bus_wdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      period_q     <= '0;
      cont_q       <= 1'b0;
      stop_pend_q  <= 1'b0;
      snap_pend_q  <= 1'b0;
      tick_count_q <= '0;
      snap_lo_q    <= '0;
      snapshot_q   <= '0;
    end else begin
      state_q      <= state_d;
      period_q     <= period_d;
      cont_q       <= cont_d;
      stop_pend_q  <= stop_pend_d;
      snap_pend_q  <= snap_pend_d;
      tick_count_q <= tick_count_d;
      snap_lo_q    <= snap_lo_d;
      snapshot_q   <= snapshot_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    period_d       = period_q;
    cont_d         = cont_q;
    stop_pend_d    = stop_pend_q;
    snap_pend_d    = snap_pend_q;
    tick_count_d   = tick_count_q;
    snap_lo_d      = snap_lo_q;
    snapshot_d     = snapshot_q;
    bus_addr       = 3'd0;
    bus_cs         = 1'b0;
    bus_wn         = 1'b1;
    bus_wdata      = 16'h0000;
    tick           = 1'b0;
    snapshot_valid = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          period_d = (period_in == 32'd0) ? DEFAULT_PERIOD : period_in;
          cont_d   = continuous_in;
          state_d  = CFG_L;
        end
      end
      CFG_L: begin
        bus_cs    = 1'b1;
        bus_wn    = 1'b0;
        bus_addr  = A_PERIODL;
        bus_wdata = period_q[15:0];
        state_d   = CFG_H;
      end
      CFG_H: begin
        bus_cs    = 1'b1;
        bus_wn    = 1'b0;
        bus_addr  = A_PERIODH;
        bus_wdata = period_q[31:16];
        state_d   = CFG_CTRL;
      end
      CFG_CTRL: begin
        // control = {STOP=0, START=1, CONT, ITO=1}
        bus_cs    = 1'b1;
        bus_wn    = 1'b0;
        bus_addr  = A_CONTROL;
        bus_wdata = {12'b0, 1'b0, 1'b1, cont_q, 1'b1};
        state_d   = RUN;
      end
      RUN: begin
        // Requests arriving this very cycle are honoured directly so the
        // pending flag only matters for requests seen in other states.
        if (irq) begin
          state_d = ACK;
        end else if (stop_pend_q || stop) begin
          state_d = STOP_WR;
        end else if (snap_pend_q || snap_req) begin
          state_d = SNAP_WR;
        end
      end
      ACK: begin
        bus_cs       = 1'b1;
        bus_wn       = 1'b0;
        bus_addr     = A_STATUS;
        bus_wdata    = 16'h0000;
        tick         = 1'b1;
        tick_count_d = tick_count_q + TICK_ONE;
        // A one-shot timer has already stopped itself.
        state_d      = cont_q ? RUN : IDLE;
      end
      STOP_WR: begin
        bus_cs    = 1'b1;
        bus_wn    = 1'b0;
        bus_addr  = A_CONTROL;
        bus_wdata = 16'h0008;
        state_d   = IDLE;
      end
      SNAP_WR: begin
        bus_cs    = 1'b1;
        bus_wn    = 1'b0;
        bus_addr  = A_SNAPL;
        bus_wdata = 16'h0000;
        state_d   = SNAP_RD_L;
      end
      SNAP_RD_L: begin
        bus_cs   = 1'b1;
        bus_addr = A_SNAPL;
        state_d  = SNAP_RD_H;
      end
      SNAP_RD_H: begin
        // readdata now carries the low half requested last cycle
        bus_cs    = 1'b1;
        bus_addr  = A_SNAPH;
        snap_lo_d = bus.readdata;
        state_d   = SNAP_CAP;
      end
      SNAP_CAP: begin
        snapshot_d     = {bus.readdata, snap_lo_q};
        snapshot_valid = 1'b1;
        state_d        = RUN;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_q != IDLE) begin
      if (stop)     stop_pend_d = 1'b1;
      if (snap_req) snap_pend_d = 1'b1;
    end
    // Entering the servicing state consumes the request; returning to IDLE
    // discards anything still outstanding.
    if (state_d == STOP_WR) stop_pend_d = 1'b0;
    if (state_d == SNAP_WR) snap_pend_d = 1'b0;
    if (state_d == IDLE) begin
      stop_pend_d = 1'b0;
      snap_pend_d = 1'b0;
    end
  end

  assign bus.address    = bus_addr;
  assign bus.chipselect = bus_cs;
  assign bus.write_n    = bus_wn;
  assign bus.writedata  = bus_wdata;

  assign running = (state_q == RUN) || (state_q == ACK) || (state_q == STOP_WR) ||
                   (state_q == SNAP_WR) || (state_q == SNAP_RD_L) ||
                   (state_q == SNAP_RD_H) || (state_q == SNAP_CAP);
  assign busy    = (state_q != IDLE) && (state_q != RUN);

  assign tick_count = tick_count_q;
  // The new value is visible in the same cycle as the valid pulse.
  assign snapshot   = (state_q == SNAP_CAP) ? {bus.readdata, snap_lo_q} : snapshot_q;

endmodule
